// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// datapath widths, reset fetch address and the held-instruction payload.
package ifu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_REQ       = 2'd0,
    ST_WAIT_RESP = 2'd1,
    ST_HOLD      = 2'd2,
    ST_WAIT_PC   = 2'd3
  } ifu_state_e;

  // Instruction word plus its fetch address and access-fault flag.
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_pkt_t;

endpackage : ifu_pkg

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch at a time. Issues a request
// at pc, captures the response, holds it for decode, then waits for the
// retiring instruction's next pc before fetching again.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr    fetch request channel (addr = current pc)
//   imem_resp_valid/data/err     fetch response channel
//   inst_valid/ready             handshake to decode
//   inst, inst_pc, inst_fault    held instruction payload
//   next_pc_valid, next_pc       redirect from execute for the retired instruction
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            next_pc_valid,
  input  logic [XLEN-1:0] next_pc
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  fetch_pkt_t      hold;
  logic            req_valid_q;
  logic            inst_valid_q;

  // Fetch FSM with pc, hold register and handshake valids updated together.
  // Responses are only looked at in ST_WAIT_RESP, so one arriving in the
  // accept cycle or after a reset is dropped without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      hold         <= '0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_req_ready) begin
            state       <= ST_WAIT_RESP;
            req_valid_q <= 1'b0;
          end
        end
        ST_WAIT_RESP: begin
          if (imem_resp_valid) begin
            hold.word    <= imem_resp_data;
            hold.pc      <= pc;
            hold.fault   <= imem_resp_err;
            state        <= ST_HOLD;
            inst_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            // Single-cycle execute path: redirect arrives with the handshake.
            if (next_pc_valid) begin
              pc          <= next_pc;
              state       <= ST_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state <= ST_WAIT_PC;
            end
          end
        end
        ST_WAIT_PC: begin
          if (next_pc_valid) begin
            pc          <= next_pc;
            state       <= ST_REQ;
            req_valid_q <= 1'b1;
          end
        end
        default: begin
          state        <= ST_REQ;
          req_valid_q  <= 1'b1;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst           = hold.word;
  assign inst_pc        = hold.pc;
  assign inst_fault     = hold.fault;

endmodule : ifu
